// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree.
// Provides the constant functions used to size the tree: level count,
// sum width, element count and bus offset per level. It also provides
// the lane extension function used at the tree input.
package adder_tree_pkg;

    // Wide enough for any lane or sum this block is expected to carry.
    localparam int EXT_W = 64;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 32'sd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Number of pipeline stages; a single lane still gets one register.
    function automatic int levels(input int bank);
        return (bank <= 32'sd1) ? 32'sd1 : clog2(bank);
    endfunction

    // Full-precision sum width; cannot overflow.
    function automatic int sum_width(input int word, input int bank);
        return word + clog2(bank);
    endfunction

    // Elements present at tree level k: ceil(bank / 2^k).
    function automatic int level_count(input int bank, input int k);
        return (bank + (32'sd1 << k) - 32'sd1) >> k;
    endfunction

    // Element offset of level k inside the flattened tree bus.
    function automatic int level_offset(input int bank, input int k);
        int acc;
        acc = 32'sd0;
        for (int j = 0; j < k; j++) begin
            acc = acc + level_count(bank, j);
        end
        return acc;
    endfunction

    // Extend the low 'word' bits of lane to EXT_W, sign or zero filled.
    function automatic logic [EXT_W-1:0] lane_ext(input logic [EXT_W-1:0] lane,
                                                  input int              word,
                                                  input logic            sgn);
        logic [EXT_W-1:0] keep;
        logic             msb;
        logic [EXT_W-1:0] res;
        keep = ~({EXT_W{1'b1}} << word);
        msb  = |(lane & (EXT_W'(1) << (word - 32'sd1)));
        if (sgn && msb) begin
            res = lane | ~keep;
        end else begin
            res = lane & keep;
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One level of the adder tree: N elements in, ceil(N/2) registered out.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   up_valid_i/up_ready_o handshake with the previous level (or block input)
//   up_data_i, up_tag_i   N packed elements and their tag
//   dn_valid_o/dn_ready_i handshake with the next level (or block output)
//   dn_data_o, dn_tag_o   ceil(N/2) packed registered sums and tag
module adder_tree_stage
    import adder_tree_pkg::*;
#(
    parameter int N         = 2,
    parameter int WIDTH     = 10,
    parameter int TAG_WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         up_valid_i,
    output logic                         up_ready_o,
    input  logic [N*WIDTH-1:0]           up_data_i,
    input  logic [TAG_WIDTH-1:0]         up_tag_i,
    output logic                         dn_valid_o,
    input  logic                         dn_ready_i,
    output logic [((N+1)/2)*WIDTH-1:0]   dn_data_o,
    output logic [TAG_WIDTH-1:0]         dn_tag_o
);

    localparam int M = (N + 1) / 2;

    logic                 valid_q, valid_d;
    logic [M*WIDTH-1:0]   data_q,  data_d;
    logic [TAG_WIDTH-1:0] tag_q,   tag_d;
    logic [M*WIDTH-1:0]   sum_s;
    logic                 load_s;

    // A stage can take new data when empty or when its content leaves now.
    assign up_ready_o = !valid_q || dn_ready_i;
    assign load_s     = up_valid_i && up_ready_o;

    // Pairwise adders; a trailing odd element passes through as if added to 0.
    for (genvar j = 0; j < M; j++) begin : g_pair
        if (2 * j + 1 < N) begin : g_add
            assign sum_s[j*WIDTH +: WIDTH] = up_data_i[(2*j)*WIDTH +: WIDTH]
                                           + up_data_i[(2*j+1)*WIDTH +: WIDTH];
        end else begin : g_fwd
            assign sum_s[j*WIDTH +: WIDTH] = up_data_i[(2*j)*WIDTH +: WIDTH];
        end
    end

    // Next-state: data only moves on a load; valid drops on hand-off alone.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (load_s) begin
            valid_d = 1'b1;
            data_d  = sum_s;
            tag_d   = up_tag_i;
        end else if (dn_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_tag_o   = tag_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined, flow-controlled reduction of BANK_SIZE lanes to one sum.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand-set handshake
//   in_data, in_tag      packed lanes (lane i at [i*WORD_SIZE +: WORD_SIZE]) and tag
//   out_valid/out_ready  sum handshake
//   out_data, out_tag    full-precision sum and the tag of its operand set
module adder_tree_pipe
    import adder_tree_pkg::*;
#(
    parameter int  WORD_SIZE = 8,
    parameter int  BANK_SIZE = 4,
    parameter int  SIGNED    = 0,
    parameter int  TAG_WIDTH = 1,
    localparam int LEVELS    = levels(BANK_SIZE),
    localparam int OUT_WIDTH = sum_width(WORD_SIZE, BANK_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_SIZE*BANK_SIZE-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [TAG_WIDTH-1:0]          out_tag
);

    // Every level's elements live side by side in one flat bus; level k
    // starts at element level_offset(BANK_SIZE, k).
    localparam int BUS_W   = OUT_WIDTH * level_offset(BANK_SIZE, LEVELS + 1);
    localparam int OUT_OFF = OUT_WIDTH * level_offset(BANK_SIZE, LEVELS);

    logic [BUS_W-1:0]     tree_s;
    logic                 vld_s [LEVELS+1];
    logic                 rdy_s [LEVELS+1];
    logic [TAG_WIDTH-1:0] tag_s [LEVELS+1];

    // Level 0: each lane widened to the final sum width.
    for (genvar i = 0; i < BANK_SIZE; i++) begin : g_ext
        assign tree_s[i*OUT_WIDTH +: OUT_WIDTH] =
            OUT_WIDTH'(lane_ext(EXT_W'(in_data[i*WORD_SIZE +: WORD_SIZE]),
                                WORD_SIZE, SIGNED != 0));
    end

    assign vld_s[0]      = in_valid;
    assign tag_s[0]      = in_tag;
    assign rdy_s[LEVELS] = out_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_stage
        localparam int N_K     = level_count(BANK_SIZE, k);
        localparam int M_K     = level_count(BANK_SIZE, k + 1);
        localparam int OFF_IN  = OUT_WIDTH * level_offset(BANK_SIZE, k);
        localparam int OFF_OUT = OUT_WIDTH * level_offset(BANK_SIZE, k + 1);

        adder_tree_stage #(
            .N         (N_K),
            .WIDTH     (OUT_WIDTH),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk_i      (clk),
            .rst_i      (rst),
            .up_valid_i (vld_s[k]),
            .up_ready_o (rdy_s[k]),
            .up_data_i  (tree_s[OFF_IN +: N_K*OUT_WIDTH]),
            .up_tag_i   (tag_s[k]),
            .dn_valid_o (vld_s[k+1]),
            .dn_ready_i (rdy_s[k+1]),
            .dn_data_o  (tree_s[OFF_OUT +: M_K*OUT_WIDTH]),
            .dn_tag_o   (tag_s[k+1])
        );
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = vld_s[LEVELS];
    assign out_data  = tree_s[OUT_OFF +: OUT_WIDTH];
    assign out_tag   = tag_s[LEVELS];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: four configurations
// (8x4 unsigned, 8x4 signed, 8x5 unsigned, 8x1 unsigned).
module tb_adder_tree_pipe;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
        int          due;   // expected output cycle, -1 = any
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   fails;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    // instance 0: WORD 8, BANK 4, unsigned
    logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready;
    logic [31:0] m_in_data;
    logic [3:0]  m_in_tag, m_out_tag;
    logic [9:0]  m_out_data;
    // instance 1: WORD 8, BANK 4, signed
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data;
    logic [3:0]  s_in_tag, s_out_tag;
    logic [9:0]  s_out_data;
    // instance 2: WORD 8, BANK 5, unsigned
    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [39:0] f_in_data;
    logic [3:0]  f_in_tag, f_out_tag;
    logic [10:0] f_out_data;
    // instance 3: WORD 8, BANK 1, unsigned
    logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready;
    logic [7:0]  o_in_data;
    logic [3:0]  o_in_tag, o_out_tag;
    logic [7:0]  o_out_data;

    adder_tree_pipe #(.WORD_SIZE(8), .BANK_SIZE(4), .SIGNED(0), .TAG_WIDTH(4)) u_main (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_data(m_in_data), .in_tag(m_in_tag), .out_valid(m_out_valid),
        .out_ready(m_out_ready), .out_data(m_out_data), .out_tag(m_out_tag));

    adder_tree_pipe #(.WORD_SIZE(8), .BANK_SIZE(4), .SIGNED(1), .TAG_WIDTH(4)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_tag(s_in_tag), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .out_tag(s_out_tag));

    adder_tree_pipe #(.WORD_SIZE(8), .BANK_SIZE(5), .SIGNED(0), .TAG_WIDTH(4)) u_five (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_data(f_in_data), .in_tag(f_in_tag), .out_valid(f_out_valid),
        .out_ready(f_out_ready), .out_data(f_out_data), .out_tag(f_out_tag));

    adder_tree_pipe #(.WORD_SIZE(8), .BANK_SIZE(1), .SIGNED(0), .TAG_WIDTH(4)) u_one (
        .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .in_data(o_in_data), .in_tag(o_in_tag), .out_valid(o_out_valid),
        .out_ready(o_out_ready), .out_data(o_out_data), .out_tag(o_out_tag));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle t is the interval after the t-th rising edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lev_of(input int inst);
        case (inst)
            0, 1:    return 2;
            2:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic ready_of(input int inst);
        case (inst)
            0:       return m_in_ready;
            1:       return s_in_ready;
            2:       return f_in_ready;
            default: return o_in_ready;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one operand set, wait for acceptance, queue the expected sum.
    task automatic send(input int inst, input logic [39:0] data, input logic [3:0] tag,
                        input logic [15:0] exp, input bit timed);
        int   waited;
        exp_t e;
        case (inst)
            0:       begin m_in_valid = 1'b1; m_in_data = data[31:0]; m_in_tag = tag; end
            1:       begin s_in_valid = 1'b1; s_in_data = data[31:0]; s_in_tag = tag; end
            2:       begin f_in_valid = 1'b1; f_in_data = data;       f_in_tag = tag; end
            default: begin o_in_valid = 1'b1; o_in_data = data[7:0];  o_in_tag = tag; end
        endcase
        waited = 0;
        @(negedge clk);
        while (!ready_of(inst) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!ready_of(inst)) begin
            checks++;
            fails++;
            $display("FAIL send_timeout inst=%0d tag=%0d: in_ready stayed 0, required 1", inst, tag);
        end else begin
            e.data = exp;
            e.tag  = tag;
            e.due  = timed ? cyc + lev_of(inst) : -1;
            case (inst)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                2:       q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
        @(posedge clk);
        #1;
        case (inst)
            0:       m_in_valid = 1'b0;
            1:       s_in_valid = 1'b0;
            2:       f_in_valid = 1'b0;
            default: o_in_valid = 1'b0;
        endcase
    endtask

    task automatic check_out(input int inst, input logic [15:0] data, input logic [3:0] tag);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (inst)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2:       if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            fails++;
            $display("FAIL out_unexpected inst=%0d cycle=%0d: got data=%0d tag=%0d, required no output",
                     inst, cyc, data, tag);
        end else if (data !== e.data || tag !== e.tag || (e.due >= 0 && cyc != e.due)) begin
            fails++;
            $display("FAIL out_sum inst=%0d: got data=%0d tag=%0d cycle=%0d, required data=%0d tag=%0d cycle=%0d",
                     inst, data, tag, cyc, e.data, e.tag, e.due);
        end
    endtask

    // Monitor: every output handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_out_valid && m_out_ready) check_out(0, 16'(m_out_data), m_out_tag);
            if (s_out_valid && s_out_ready) check_out(1, 16'(s_out_data), s_out_tag);
            if (f_out_valid && f_out_ready) check_out(2, 16'(f_out_data), f_out_tag);
            if (o_out_valid && o_out_ready) check_out(3, 16'(o_out_data), o_out_tag);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        m_in_valid = 1'b0; m_in_data = '0; m_in_tag = '0; m_out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_in_tag = '0; s_out_ready = 1'b1;
        f_in_valid = 1'b0; f_in_data = '0; f_in_tag = '0; f_out_ready = 1'b1;
        o_in_valid = 1'b0; o_in_data = '0; o_in_tag = '0; o_out_ready = 1'b1;
        idle(2);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 16'(m_out_valid), 16'd0);
        check("rst_out_data",  16'(m_out_data),  16'd0);
        check("rst_out_tag",   16'(m_out_tag),   16'd0);
        check("rst_in_ready",  16'(m_in_ready),  16'd1);
        check("rst_in_ready_b1", 16'(o_in_ready), 16'd1);
        idle(1);

        // Basic sum, latency 2, single-cycle output
        send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 4'd1, 16'd10, 1'b1);
        idle(4);

        // Maximum operands then a small set, back to back
        send(0, {8'd255, 8'd255, 8'd255, 8'd15}, 4'd2, 16'd780, 1'b1);
        send(0, {8'd1, 8'd2, 8'd3, 8'd4},       4'd3, 16'd10,  1'b1);
        idle(4);

        // Signed lanes
        send(1, {8'h80, 8'h80, 8'h80, 8'h80}, 4'd1, 16'h0200, 1'b1);
        send(1, {8'd127, 8'hFF, 8'd0, 8'd0},  4'd2, 16'd126,  1'b1);
        idle(4);

        // Non-power-of-two bank and single lane
        send(2, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 4'd1, 16'd15, 1'b1);
        send(3, 40'd7, 4'd1, 16'd7, 1'b1);
        idle(5);

        // Backpressure: two sets fill the pipe, in_ready drops, output holds
        m_out_ready = 1'b0;
        send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 4'd1, 16'd10, 1'b0);
        send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 4'd2, 16'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready",  16'(m_in_ready),  16'd0);
            check("bp_out_valid", 16'(m_out_valid), 16'd1);
            check("bp_out_data",  16'(m_out_data),  16'd10);
            check("bp_out_tag",   16'(m_out_tag),   16'd1);
        end
        @(posedge clk);
        #1;
        // Drain and accept in the same cycle; stream must flow with no gaps
        c = cyc;
        if (q0.size() == 2) begin
            q0[0].due = c;
            q0[1].due = c + 1;
        end
        m_out_ready = 1'b1;
        send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 4'd3, 16'd10, 1'b1);
        send(0, {8'd1, 8'd2, 8'd3, 8'd4}, 4'd4, 16'd10, 1'b1);
        idle(4);

        // Reset with two sets in flight; a set offered during reset is dropped
        m_out_ready = 1'b0;
        send(0, {8'd9, 8'd9, 8'd9, 8'd9}, 4'd5, 16'd36, 1'b0);
        send(0, {8'd8, 8'd8, 8'd8, 8'd8}, 4'd6, 16'd32, 1'b0);
        rst = 1'b1;
        m_in_valid = 1'b1;
        m_in_data  = {8'd50, 8'd50, 8'd50, 8'd50};
        m_in_tag   = 4'd9;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_in_valid = 1'b0;
        q0.delete();
        m_out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 16'(m_out_valid), 16'd0);
        check("mid_rst_out_data",  16'(m_out_data),  16'd0);
        check("mid_rst_out_tag",   16'(m_out_tag),   16'd0);
        check("mid_rst_in_ready",  16'(m_in_ready),  16'd1);
        idle(5);
        send(0, {8'd10, 8'd20, 8'd30, 8'd40}, 4'd7, 16'd100, 1'b1);
        idle(4);

        // Everything queued must have come out
        n = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size() + q3.size()) > 0) begin
            fails++;
            $display("FAIL drain: got %0d sums outstanding, required 0",
                     q0.size() + q1.size() + q2.size() + q3.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised successor to the existing two-level pairwise adder block.
- Reduces BANK_SIZE words to one full-precision sum through a fully registered binary tree, one pipeline register per tree level.
- Adds valid/ready flow control with per-stage bubble collapsing, a signed/unsigned mode, non-power-of-two bank sizes, and a sideband tag that travels alongside the data.
- Sits between a packed multi-lane datapath and any single-lane consumer (accumulator, FIFO, reduction engine).

Parameters:
- WORD_SIZE, 8, width of each input lane.
- BANK_SIZE, 4, number of input lanes (>=1; need not be a power of two).
- SIGNED, 0, 1 = lanes are two's complement and sign-extended; 0 = zero-extended.
- TAG_WIDTH, 1, width of the sideband tag carried with each operand set.
- LEVELS, derived = max(1, clog2(BANK_SIZE)), number of pipeline stages.
- OUT_WIDTH, derived = WORD_SIZE + clog2(BANK_SIZE), sum width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set on in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  WORD_SIZE*BANK_SIZE  packed lanes; lane i = bits [i*WORD_SIZE +: WORD_SIZE].
- in_tag  in  TAG_WIDTH  sideband, passed through unmodified.
- out_valid  out  1  out_data holds a finished sum.
- out_ready  in  1  consumer accepts the sum this cycle.
- out_data  out  OUT_WIDTH  sum of all lanes.
- out_tag  out  TAG_WIDTH  tag of the operand set that produced out_data.

Behaviour:
- Reset: one cycle with rst=1 clears every stage valid. out_valid=0, out_data=0, out_tag=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all in-flight sums are discarded with no partial output. rst overrides in_valid in the same cycle.
- Stage k (0..LEVELS-1) has valid v[k] plus a data/tag register.
  - r[LEVELS] = out_ready; r[k] = !v[k] || r[k+1].
  - in_ready = r[0].
  - Stage 0 loads when in_valid && r[0]. Stage k>0 loads when v[k-1] && r[k].
  - v[k] becomes 1 on a load. It becomes 0 when stage k hands off downstream without a new load.
  - Data registers are enabled only on a load and hold otherwise.
- Level arithmetic:
  - Level 0 extends each lane to OUT_WIDTH (sign-extended if SIGNED=1, zero-extended otherwise).
  - Each level adds adjacent pairs. An odd element at the end of a level is forwarded unchanged (treated as +0).
  - Non-power-of-two BANK_SIZE pads with zero lanes. No overflow is possible at OUT_WIDTH.
- Latency: LEVELS cycles from accept to out_valid when out_ready stays high. Throughput is one set per cycle.
- BANK_SIZE=1: one stage, out_data = extended lane 0, latency 1.
- Backpressure:
  - With out_ready=0, out_data and out_tag hold stable while out_valid=1.
  - Upstream stages keep filling bubbles until the pipe is full (LEVELS entries). in_ready then drops combinationally.
  - No set is lost, duplicated or reordered.
- Simultaneous events: out_ready=1 with in_valid=1 on a full pipe means the output drains and a new set is accepted in the same cycle.
- in_data and in_tag are sampled only on acceptance. in_valid may drop without in_ready.

Decomposition:
- Shared package adder_tree_pkg:
  - clog2 constant function.
  - levels(bank) and sum_width(word, bank) helper functions.
  - lane_ext function (signed/zero extension).
- Sub-module adder_tree_stage:
  - One level: N inputs to ceil(N/2) outputs.
  - Parameters N, WIDTH, TAG_WIDTH; carries the valid register and the ready computation.
- Top module instantiates LEVELS copies of adder_tree_stage in a generate loop.

Test Plan:
1. WORD=8, BANK=4, SIGNED=0, out_ready=1; in_data {8'd1,8'd2,8'd3,8'd4}, tag 1 -> after 2 cycles out_valid=1, out_data=10'd10, out_tag=1, for exactly one cycle.
2. Max value and throughput: {255,255,255,15} then {1,2,3,4} back-to-back -> out_data 10'd780 then 10'd10 on consecutive cycles.
3. SIGNED=1: {-128,-128,-128,-128} -> out_data=10'h200 (-512). {127,-1,0,0} -> 126.
4. Backpressure:
   - Send sets with tags 1..4 while out_ready=0 -> in_ready drops after 2 accepts, and out_data=10 holds.
   - Raise out_ready -> tags emerge 1,2,3,4 in order, with no gaps once the stream flows.
5. BANK=5: {1,2,3,4,5} -> out_data=11'd15 after 3 cycles. BANK=1: {8'd7} -> 8'd7 after 1 cycle.
6. Assert rst for one cycle with 2 sets in flight -> out_valid=0 and out_data=0 the next cycle, no stale output afterward. A new set after reset sums correctly.
